// File: rtl/rr_arb_pkg.sv
// Round-robin arbiter shared types and helpers.
// Index width is derived from the request count.
package rr_arb_pkg;

  localparam int REQCNT_DEF = 16;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDXW_DEF = idx_w(REQCNT_DEF);

  typedef logic [IDXW_DEF-1:0] idx_t;

endpackage

// File: rtl/rr_arb_if.sv
// Request/grant bundle between the requester bank
// and the round-robin arbiter.
interface rr_arb_if
  import rr_arb_pkg::*;
#(
  parameter int REQCNT = REQCNT_DEF
) ();

  localparam int IDXW = idx_w(REQCNT);

  logic [REQCNT-1:0] req_i;
  logic              req_val_i;
  logic [IDXW-1:0]   req_num_o;
  logic              req_num_val_o;

  modport master (
    output req_i,
    output req_val_i,
    input  req_num_o,
    input  req_num_val_o
  );

  modport slave (
    input  req_i,
    input  req_val_i,
    output req_num_o,
    output req_num_val_o
  );

endinterface

// File: rtl/rr_rotate_ffs.sv
// Circular find-first-set starting just after ptr.
// The ptr index itself is examined last.
module rr_rotate_ffs
  import rr_arb_pkg::*;
#(
  parameter  int REQCNT = REQCNT_DEF,
  localparam int IDXW   = idx_w(REQCNT)
) (
  input  logic [REQCNT-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic [IDXW-1:0]   win,
  output logic              found
);

  int j;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= REQCNT; k++) begin
      j = int'(ptr) + k;
      if (j >= REQCNT) j = j - REQCNT;
      if (!found && req[IDXW'(j)]) begin
        found = 1'b1;
        win   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arb_top.sv
// Round-robin arbiter: registered grant index with
// a last-grant pointer driving rotating priority.
module rr_arb_top
  import rr_arb_pkg::*;
#(
  parameter int REQCNT = REQCNT_DEF
) (
  input logic  clk_i,
  input logic  rst_i,
  rr_arb_if.slave bus
);

  localparam int IDXW = idx_w(REQCNT);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] num_q;
  logic            val_q;
  logic [IDXW-1:0] win;
  logic            found;

  rr_rotate_ffs #(
    .REQCNT(REQCNT)
  ) u_ffs (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .win   (win),
    .found (found)
  );

  // Pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= IDXW'(REQCNT - 1);
      num_q <= '0;
      val_q <= 1'b0;
    end else if (bus.req_val_i && found) begin
      ptr_q <= win;
      num_q <= win;
      val_q <= 1'b1;
    end else begin
      val_q <= 1'b0;
    end
  end

  assign bus.req_num_o     = num_q;
  assign bus.req_num_val_o = val_q;

endmodule

// File: tb/tb_rr_arb_top.sv
// Scoreboard bench for rr_arb_top with REQCNT=16.
// Directed vectors push expected grants; a monitor pops them.
module tb_rr_arb_top;
  import rr_arb_pkg::*;

  logic clk;
  logic rst_n;

  rr_arb_if #(.REQCNT(16)) bus ();

  rr_arb_top #(.REQCNT(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  idx_t q[$];

  int   cyc = 0;
  bit   hold_phase = 1'b0;
  int   last_g[16];
  bit   seen_g[16];
  int   max_wait = 0;
  int   low_hit = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    idx_t e;
    int   g;
    #1;
    cyc++;
    if (rst_n && bus.req_num_val_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant got=%0d want=none",
                 bus.req_num_o);
      end else begin
        e = q.pop_front();
        chk("grant", int'(bus.req_num_o), int'(e));
      end
      if (hold_phase) begin
        g = int'(bus.req_num_o);
        if (g < 8) low_hit++;
        if (seen_g[g] && (cyc - last_g[g] - 1) > max_wait)
          max_wait = cyc - last_g[g] - 1;
        seen_g[g] = 1'b1;
        last_g[g] = cyc;
      end
    end
  end

  task automatic step(input logic [15:0] r, input int exp);
    @(negedge clk);
    bus.req_i = r;
    if (exp >= 0) q.push_back(idx_t'(exp));
  endtask

  task automatic idle(input logic [15:0] r, input logic v,
                      input int exp_num);
    @(negedge clk);
    bus.req_i     = r;
    bus.req_val_i = v;
    @(posedge clk);
    #2;
    chk("idle_val", int'(bus.req_num_val_o), 0);
    chk("idle_num", int'(bus.req_num_o), exp_num);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    rst_n         = 1'b0;
    bus.req_i     = '0;
    bus.req_val_i = 1'b0;
    #12;
    chk("rst_val", int'(bus.req_num_val_o), 0);
    chk("rst_num", int'(bus.req_num_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // drain all sixteen, clearing each granted line
    bus.req_val_i = 1'b1;
    r = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      step(r, k);
      r[k] = 1'b0;
    end
    idle(16'h0000, 1'b1, 15);

    // upper half held constant
    hold_phase = 1'b1;
    for (int k = 0; k < 16; k++) step(16'hFF00, 8 + (k % 8));
    idle(16'h0000, 1'b1, 15);
    hold_phase = 1'b0;
    chk("max_wait", max_wait, 7);
    chk("low_hit", low_hit, 0);

    // lone persistent requester
    for (int k = 0; k < 6; k++) step(16'h0020, 5);
    idle(16'h0000, 1'b1, 5);

    // wrap-around past 15
    step(16'h4000, 14);
    step(16'h8004, 15);
    step(16'h0004, 2);
    idle(16'h0000, 1'b1, 2);

    // gating by req_val_i
    idle(16'h00F0, 1'b0, 2);
    idle(16'h00F0, 1'b0, 2);
    idle(16'h00F0, 1'b0, 2);
    bus.req_val_i = 1'b1;
    step(16'h00F0, 4);
    step(16'h00E0, 5);
    idle(16'h0000, 1'b1, 5);

    // reset mid-operation
    step(16'h0200, 9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_val", int'(bus.req_num_val_o), 0);
    chk("midrst_num", int'(bus.req_num_o), 0);
    @(posedge clk);
    #1;
    chk("inrst_val", int'(bus.req_num_val_o), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.req_i = 16'hFFFF;
    q.push_back(idx_t'(0));
    step(16'hFFFE, 1);
    idle(16'h0000, 1'b1, 1);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_top.md
Name: rr_arb_top

Overview:
- Parameterised round-robin arbiter over REQCNT request lines.
- Each clock with a valid request set, it grants one requester, encoded as an index.
- Priority rotates so the requester after the last grant is served first; starvation-free.
- Sits between a bank of requesters and a shared resource. Requesters drop their line once they see their index granted.

Parameters:
- REQCNT, default 16, number of request lines; must be ≥2. Powers of two are the primary target.
- Derived localparam IDXW = $clog2(REQCNT), the index width.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  REQCNT  request vector; bit i = requester i pending.
- req_val_i  in  1  qualifies req_i; arbitration occurs only when high.
- req_num_o  out  IDXW  index of granted requester.
- req_num_val_o  out  1  high in cycles where req_num_o carries a fresh grant.

Behaviour:
- Reset (rst_i low, asynchronous assert, synchronous-safe deassert on clk_i):
  - req_num_o = 0.
  - req_num_val_o = 0.
  - Internal last-grant pointer = REQCNT-1, so index 0 has highest priority after reset.
- Arbitration (combinational, each cycle):
  - Search req_i circularly starting at pointer+1, wrapping from REQCNT-1 to 0.
  - The first set bit is the winner.
  - The pointer's own index is searched last, so a lone persistent requester is re-granted every cycle.
- Registered output, 1-cycle latency: on a rising edge with req_val_i=1 and req_i≠0:
  - req_num_o <= winner.
  - req_num_val_o <= 1.
  - pointer <= winner.
- On a rising edge with req_val_i=0 or req_i==0:
  - req_num_val_o <= 0.
  - req_num_o and pointer hold their values.
- req_val_i=1 with req_i==0 is treated as no request; no grant is issued.
- One grant per cycle. Back-to-back grants are allowed every cycle.
- Requester handshake: a requester drops its line on/after seeing its index on req_num_o with req_num_val_o=1. If it keeps the line asserted, it is treated as a new request and re-enters rotation.
- Fairness: with a set of N requesters held continuously, each is granted exactly once per N consecutive grants. Maximum wait for any held request ≤ REQCNT-1 grant cycles.
- Simultaneous new requests are resolved purely by rotation order relative to the pointer.
- Reset mid-operation: outputs clear immediately, pointer returns to REQCNT-1, and the in-flight grant is lost.
- No X-propagation: all outputs are defined after reset regardless of req_i.

Decomposition:
- Package rr_arb_pkg:
  - default REQCNT constant.
  - function clog2-based index width helper.
  - typedef for the index type.
- Sub-module rr_rotate_ffs: combinational "find first set starting after pointer".
  - Inputs: req vector, pointer.
  - Outputs: winner index, found flag.
  - Implemented by rotate, priority-encode, un-rotate (or double-width mask trick).
- Top holds the pointer and output registers.

Test Plan:
- All-requests drain (REQCNT=16), each granted line cleared at next negedge:
  - req_i=16'hFFFF after reset → grants 0,1,2,…,15 on consecutive cycles.
  - Then req_num_val_o=0 with req_num_o holding 15.
- Upper-half held (REQCNT=16):
  - req_i=16'hFF00 held constant → grants cycle 8,9,…,15,8,9,…
  - Measured maximum wait of any requester = 7 cycles; never grants indices 0–7.
- Single persistent requester:
  - req_i=16'h0020 → req_num_o=5 every cycle, req_num_val_o=1.
- Wrap-around:
  - Drive pointer to 14 via a grant of 14, then req_i = bits {15,2} → next grant 15, then 2.
- Gating:
  - req_val_i=0 with req_i=16'h00F0 → req_num_val_o=0 and pointer unchanged.
  - Raise req_val_i → first grant is the next index after the prior pointer.
  - req_val_i=1 with req_i=0 → no grant.
- Reset mid-operation:
  - Assert rst_i low while granting index 9 → outputs go to 0 immediately.
  - After release with req_i=16'hFFFF → first grant is 0.
